mux_8to1: RTL and testbench

// - Registered 8-to-1 multiplexer: each rising clk edge it samples data_in and

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_sel_decode.sv | 19 +
 rtl/mux_8to1.sv | 74 +++++++
 tb/tb_mux_8to1.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants, the select type and a one-hot helper for the mux_8to1 slice.
package mux_pkg;

  localparam int MUX_N_IN_DEF  = 8;
  localparam int MUX_WIDTH_DEF = 1;
  localparam int MUX_SEL_W_DEF = 3;

  typedef logic [MUX_SEL_W_DEF-1:0] sel_t;

  // Reference one-hot of a select value, for benches and models.
  function automatic logic [MUX_N_IN_DEF-1:0] onehot(input sel_t sel);
    logic [MUX_N_IN_DEF-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_sel_decode.sv
// Select-to-one-hot decoder; a select at or beyond N_IN yields all zeros.
module mux_sel_decode
  import mux_pkg::*;
#(
  parameter int N_IN  = MUX_N_IN_DEF,
  parameter int SEL_W = MUX_SEL_W_DEF
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  sel_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_dec
      assign sel_onehot[gi] = (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mux_8to1.sv
// Registered N-lane AND-OR multiplexer with one cycle of latency.
// Optional registered lane parity output when MUX_PARITY_EN is defined.
module mux_8to1
  import mux_pkg::*;
#(
  parameter int N_IN  = MUX_N_IN_DEF,
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int SEL_W = MUX_SEL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      selection_in,
  output logic [WIDTH-1:0]      mux_out
`ifdef MUX_PARITY_EN
  ,
  output logic                  mux_parity
`endif
);

  logic [N_IN-1:0]  sel_onehot;
  logic [WIDTH-1:0] lane_masked [N_IN];
  logic [WIDTH-1:0] lane_next;
  logic [WIDTH-1:0] mux_out_reg;

  mux_sel_decode #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel        (selection_in),
    .sel_onehot (sel_onehot)
  );

  // Masking each lane with its decode bit keeps unknowns on unselected lanes out.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_lane
      assign lane_masked[gi] = data_in[gi*WIDTH +: WIDTH] & {WIDTH{sel_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    lane_next = '0;
    for (int i = 0; i < N_IN; i++) begin
      lane_next = lane_next | lane_masked[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out_reg <= '0;
    end else begin
      mux_out_reg <= lane_next;
    end
  end

  assign mux_out = mux_out_reg;

`ifdef MUX_PARITY_EN
  logic parity_reg;

  // An out-of-range select leaves lane_next at zero, so parity is zero too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= ^lane_next;
    end
  end

  assign mux_parity = parity_reg;
`endif

endmodule

// File: tb/tb_mux_8to1.sv
// Directed bench for mux_8to1: a default 8x1 instance and a 6x4 instance
// for out-of-range selects (parity checked when MUX_PARITY_EN is defined).
module tb_mux_8to1;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic [2:0]  selection_in;
  logic [0:0]  mux_out;
  logic [23:0] data_w;
  logic [2:0]  sel_w;
  logic [3:0]  mux_out_w;
`ifdef MUX_PARITY_EN
  logic        mux_parity;
  logic        mux_parity_w;
`endif

  int n_vec;
  int n_err;

  mux_8to1 u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .selection_in (selection_in),
    .mux_out      (mux_out)
`ifdef MUX_PARITY_EN
    ,
    .mux_parity   (mux_parity)
`endif
  );

  mux_8to1 #(
    .N_IN  (6),
    .WIDTH (4),
    .SEL_W (3)
  ) u_dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_w),
    .selection_in (sel_w),
    .mux_out      (mux_out_w)
`ifdef MUX_PARITY_EN
    ,
    .mux_parity   (mux_parity_w)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end else begin
      $display("ok   %s: got %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // data_in = 8'b1010_0110, lane value per select 0..7
  logic [0:0] sweep_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b1;
    data_in      = 8'hFF;
    selection_in = 3'd5;
    data_w       = 24'hFC53B0;  // lanes 5..0 = F,C,5,3,B,0
    sel_w        = 3'd1;

    // Async reset: assert well before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_async", 32'(mux_out), 32'd0);
    check("reset_async_w", 32'(mux_out_w), 32'd0);
    tick();
    check("reset_hold", 32'(mux_out), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 32'(mux_out), 32'd0);
    tick();
    check("release_first", 32'(mux_out), 32'd1);
    check("wide_sel1", 32'(mux_out_w), 32'hB);
`ifdef MUX_PARITY_EN
    check("wide_par_sel1", 32'(mux_parity_w), 32'd1);
`endif

    // Sweep every select across a fixed data pattern.
    data_in = 8'b1010_0110;
    for (int s = 0; s < 8; s++) begin
      selection_in = 3'(s);
      tick();
      check($sformatf("sweep_sel%0d", s), 32'(mux_out), 32'(sweep_exp[s]));
    end

    // Latency: a mid-cycle select change only lands at the next edge.
    data_in      = 8'h08;
    selection_in = 3'd2;
    tick();
    check("lat_sel2", 32'(mux_out), 32'd0);
    #3 selection_in = 3'd3;
    #1;
    check("lat_hold", 32'(mux_out), 32'd0);
    tick();
    check("lat_sel3", 32'(mux_out), 32'd1);

    // Unknowns on unselected lanes must not leak through.
    data_in      = 8'bxxxx_xxx1;
    selection_in = 3'd0;
    tick();
    check("isolate", 32'(mux_out), 32'd1);

    // Mid-run reset pulse of 3 ns between edges.
    data_in      = 8'h10;
    selection_in = 3'd4;
    tick();
    check("pre_pulse", 32'(mux_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("pulse_clear", 32'(mux_out), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("pulse_released", 32'(mux_out), 32'd0);
    tick();
    check("pulse_recover", 32'(mux_out), 32'd1);

    // Wide instance: in-range and out-of-range selects.
    sel_w = 3'd2;
    tick();
    check("wide_sel2", 32'(mux_out_w), 32'h3);
`ifdef MUX_PARITY_EN
    check("wide_par_sel2", 32'(mux_parity_w), 32'd0);
`endif
    sel_w = 3'd5;
    tick();
    check("wide_sel5", 32'(mux_out_w), 32'hF);
    sel_w = 3'd7;
    tick();
    check("wide_sel7_oor", 32'(mux_out_w), 32'h0);
`ifdef MUX_PARITY_EN
    check("wide_par_sel7", 32'(mux_parity_w), 32'd0);
`endif
    sel_w = 3'd4;
    tick();
    check("wide_sel4", 32'(mux_out_w), 32'hC);
    sel_w = 3'd6;
    tick();
    check("wide_sel6_oor", 32'(mux_out_w), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
